// File: rtl/mem_access_ctrl.sv
// Memory access controller: owns MAR/MDR, runs a req/ack handshake against
// variable-latency memory and returns a one-cycle ready pulse (o_R).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access in flight; waits for i_MIO_EN with Armed set
// REQ   | o_MemReq high with latched address/data/WE until i_MemAck
// DONE  | o_R high for one cycle; read data available for the MDR
module mem_access_ctrl (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic [15:0] i_Bus,
  input  logic        i_LD_MAR,
  input  logic        i_LD_MDR,
  input  logic        i_MIO_EN,
  input  logic        i_R_W,
  input  logic        i_MemAck,
  input  logic [15:0] i_MemRData,
  output logic [15:0] o_MAR,
  output logic [15:0] o_MDR,
  output logic        o_R,
  output logic        o_MemReq,
  output logic        o_MemWE,
  output logic [15:0] o_MemAddr,
  output logic [15:0] o_MemWData
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        armed_q, armed_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic [15:0] addr_lat_q, addr_lat_d;
  logic [15:0] wdata_lat_q, wdata_lat_d;
  logic        we_lat_q, we_lat_d;
  logic [15:0] rdata_buf_q, rdata_buf_d;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q     <= IDLE;
      armed_q     <= 1'b1;
      mar_q       <= 16'h0000;
      mdr_q       <= 16'h0000;
      addr_lat_q  <= 16'h0000;
      wdata_lat_q <= 16'h0000;
      we_lat_q    <= 1'b0;
      rdata_buf_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      addr_lat_q  <= addr_lat_d;
      wdata_lat_q <= wdata_lat_d;
      we_lat_q    <= we_lat_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    addr_lat_d  = addr_lat_q;
    wdata_lat_d = wdata_lat_q;
    we_lat_d    = we_lat_q;
    rdata_buf_d = rdata_buf_q;

    unique case (state_q)
      IDLE: begin
        if (!i_MIO_EN) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          // Latch pre-edge MAR/MDR so same-cycle loads do not leak in.
          state_d     = REQ;
          armed_d     = 1'b0;
          addr_lat_d  = mar_q;
          wdata_lat_d = mdr_q;
          we_lat_d    = i_R_W;
        end
      end
      REQ: begin
        if (i_MemAck) begin
          state_d = DONE;
          if (!we_lat_q) begin
            rdata_buf_d = i_MemRData;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!i_MIO_EN) begin
          armed_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mar_d = mar_q;
    if (i_LD_MAR) begin
      mar_d = i_Bus;
    end
  end

  // While the control FSM waits on R (MIO_EN high) the MDR holds.
  always_comb begin
    mdr_d = mdr_q;
    if (i_LD_MDR) begin
      if (state_q == DONE && !we_lat_q) begin
        mdr_d = rdata_buf_q;
      end else if (!i_MIO_EN) begin
        mdr_d = i_Bus;
      end
    end
  end

  always_comb begin
    o_MAR      = mar_q;
    o_MDR      = mdr_q;
    o_R        = (state_q == DONE);
    o_MemReq   = (state_q == REQ);
    o_MemWE    = o_MemReq & we_lat_q;
    o_MemAddr  = o_MemReq ? addr_lat_q  : 16'h0000;
    o_MemWData = o_MemReq ? wdata_lat_q : 16'h0000;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: read/write handshakes, re-arm,
// mid-access MAR load, reset during REQ and MIO_EN drop.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [15:0] bus;
  logic        ld_mar, ld_mdr, mio_en, r_w, mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] mar, mdr, mem_addr, mem_wdata;
  logic        r, mem_req, mem_we;

  int n_checks = 0;
  int n_err    = 0;
  int r_cnt    = 0;
  int r_base;

  mem_access_ctrl dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_l),
    .i_Bus      (bus),
    .i_LD_MAR   (ld_mar),
    .i_LD_MDR   (ld_mdr),
    .i_MIO_EN   (mio_en),
    .i_R_W      (r_w),
    .i_MemAck   (mem_ack),
    .i_MemRData (mem_rdata),
    .o_MAR      (mar),
    .o_MDR      (mdr),
    .o_R        (r),
    .o_MemReq   (mem_req),
    .o_MemWE    (mem_we),
    .o_MemAddr  (mem_addr),
    .o_MemWData (mem_wdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (r === 1'b1) r_cnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, ".req"},   mem_req,   0);
    chk({tag, ".r"},     r,         0);
    chk({tag, ".we"},    mem_we,    0);
    chk({tag, ".addr"},  mem_addr,  0);
    chk({tag, ".wdata"}, mem_wdata, 0);
  endtask

  initial begin
    rst_l = 0; bus = 0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0;
    mem_ack = 0; mem_rdata = 0;
    step(); step();
    chk_idle_outs("rst");
    chk("rst.mar", mar, 0);
    chk("rst.mdr", mdr, 0);
    rst_l = 1;

    // Read, zero wait states
    bus = 16'h3000; ld_mar = 1; step();
    chk("rd0.mar", mar, 16'h3000);
    ld_mar = 0; mio_en = 1; r_w = 0; ld_mdr = 1; bus = 16'h1111;
    r_base = r_cnt;
    step();
    chk("rd0.req", mem_req, 1);
    chk("rd0.addr", mem_addr, 16'h3000);
    chk("rd0.we", mem_we, 0);
    chk("rd0.mdr_hold", mdr, 0);
    mem_ack = 1; mem_rdata = 16'hBEEF;
    step();
    mem_ack = 0; mem_rdata = 0;
    chk("rd0.r", r, 1);
    chk("rd0.req_off", mem_req, 0);
    chk("rd0.addr_off", mem_addr, 0);
    step();
    chk("rd0.r_off", r, 0);
    chk("rd0.mdr", mdr, 16'hBEEF);
    mio_en = 0; ld_mdr = 0; step();
    chk("rd0.rcnt", r_cnt - r_base, 1);

    // Write, three wait states
    bus = 16'hFE06; ld_mar = 1; step();
    bus = 16'h0041; ld_mar = 0; ld_mdr = 1; step();
    chk("wr.mar", mar, 16'hFE06);
    chk("wr.mdr", mdr, 16'h0041);
    mio_en = 1; r_w = 1; bus = 16'hDEAD;
    r_base = r_cnt;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("wr.req%0d", i), mem_req, 1);
      chk($sformatf("wr.we%0d", i), mem_we, 1);
      chk($sformatf("wr.wdata%0d", i), mem_wdata, 16'h0041);
      chk($sformatf("wr.addr%0d", i), mem_addr, 16'hFE06);
      chk($sformatf("wr.r%0d", i), r, 0);
      if (i == 3) begin
        mem_ack = 1; mem_rdata = 16'h5A5A;
      end
    end
    step();
    mem_ack = 0;
    chk("wr.r", r, 1);
    step();
    chk("wr.r_off", r, 0);
    chk("wr.mdr_kept", mdr, 16'h0041);
    mio_en = 0; ld_mdr = 0; r_w = 0; step();
    chk("wr.rcnt", r_cnt - r_base, 1);

    // Mid-access MAR load, then no re-arm while MIO_EN stays high
    bus = 16'h4000; ld_mar = 1; step();
    ld_mar = 0; mio_en = 1; step();
    chk("mar.req", mem_req, 1);
    bus = 16'h1234; ld_mar = 1; step();
    ld_mar = 0;
    chk("mar.addr", mem_addr, 16'h4000);
    chk("mar.mar", mar, 16'h1234);
    mem_ack = 1; mem_rdata = 16'h5555; step();
    mem_ack = 0;
    chk("mar.r", r, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rearm.noreq%0d", i), mem_req, 0);
    end
    mio_en = 0; step();
    mio_en = 1; step();
    chk("rearm.req", mem_req, 1);
    chk("rearm.addr", mem_addr, 16'h1234);
    mem_ack = 1; mem_rdata = 16'h0000; step();
    mem_ack = 0; mio_en = 0; step();
    step();

    // Reset in the middle of REQ; late ack must be ignored
    bus = 16'h7777; ld_mar = 1; step();
    ld_mar = 0; mio_en = 1; step();
    chk("rst2.req", mem_req, 1);
    r_base = r_cnt;
    rst_l = 0; mio_en = 0; step();
    rst_l = 1;
    chk_idle_outs("rst2");
    chk("rst2.mdr", mdr, 0);
    chk("rst2.mar", mar, 0);
    step();
    mem_ack = 1; mem_rdata = 16'hABCD; step();
    mem_ack = 0;
    chk_idle_outs("rst2.ack");
    step();
    chk("rst2.mdr_after", mdr, 0);
    chk("rst2.rcnt", r_cnt - r_base, 0);

    // MIO_EN falls in the first REQ cycle
    bus = 16'h5000; ld_mar = 1; step();
    ld_mar = 0; mio_en = 1; r_w = 0; r_base = r_cnt; step();
    chk("drop.req0", mem_req, 1);
    mio_en = 0; step();
    chk("drop.req1", mem_req, 1);
    step();
    chk("drop.req2", mem_req, 1);
    mem_ack = 1; mem_rdata = 16'h00FF; bus = 16'h9999; step();
    mem_ack = 0; mem_rdata = 0;
    chk("drop.r", r, 1);
    ld_mdr = 1; step();
    ld_mdr = 0;
    chk("drop.mdr", mdr, 16'h00FF);
    chk("drop.rcnt", r_cnt - r_base, 1);
    mio_en = 1; step();
    chk("drop.rearmed", mem_req, 1);
    chk("drop.addr", mem_addr, 16'h5000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
